// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Brief    : Shared types and constants for the branch redirect controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Detects EX-stage branch mispredictions, flushes IF/ID, stalls EX
//            and hands a registered redirect PC to fetch over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk_1,
    input  logic             i_rstn_1,
    input  logic             i_exValid_1,
    input  logic             i_isCtrl_1,
    input  logic [31:0]      i_exPC_32,
    input  logic             i_isBranch_1,
    input  logic [31:0]      i_branchPC_32,
    input  logic             i_predTaken_1,
    input  logic [31:0]      i_predPC_32,
    input  logic             i_redirReady_1,
    input  logic             i_cntClr_1,
    output logic             o_redirValid_1,
    output logic [31:0]      o_redirPC_32,
    output logic             o_flush_1,
    output logic             o_exStall_1,
    output logic [CNT_W-1:0] o_branchCnt_W,
    output logic [CNT_W-1:0] o_mispredCnt_W
);

    state_t             state;
    state_t             state_nxt;
    logic               in_redir;
    logic               resolve;
    logic               mispredict;
    logic [31:0]        correct_pc;
    logic [31:0]        redir_pc;
    logic [CNT_W-1:0]   branch_cnt;
    logic [CNT_W-1:0]   mispred_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // EX inputs only count while IDLE; in REDIR the EX op is stalled.
    assign resolve    = i_exValid_1 & i_isCtrl_1 & (state == IDLE);
    assign correct_pc = i_isBranch_1 ? i_branchPC_32 : (i_exPC_32 + PC_INC);
    assign mispredict = resolve &
                        ((i_isBranch_1 != i_predTaken_1) |
                         (i_isBranch_1 & i_predTaken_1 & (i_branchPC_32 != i_predPC_32)));

    always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
        if (!i_rstn_1) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_redir  = 1'b0;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                in_redir = 1'b1;
                if (i_redirReady_1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
        if (!i_rstn_1) begin
            redir_pc <= RESET_PC;
        end else if (mispredict) begin
            redir_pc <= correct_pc;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
        if (!i_rstn_1) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (i_cntClr_1) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (mispredict) begin
                mispred_cnt <= sat_inc(mispred_cnt);
            end
        end
    end

    assign o_redirValid_1 = in_redir;
    assign o_flush_1      = in_redir;
    assign o_exStall_1    = in_redir;
    assign o_redirPC_32   = redir_pc;
    assign o_branchCnt_W  = branch_cnt;
    assign o_mispredCnt_W = mispred_cnt;

endmodule

`default_nettype wire

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences pipeline redirection after branch resolution in EX. Compares the resolved outcome of each control-flow instruction (from the EX-stage branch unit) against the prediction carried down from fetch. On a misprediction it raises flush to IF/ID, stalls EX, and holds a registered redirect PC to the fetch unit until fetch accepts it over a valid/ready handshake. It also keeps saturating counts of resolved control-flow instructions and mispredictions for performance monitoring.

## Interface
- RESET_PC, 32'h0000_0000, value of o_redirPC_32 out of reset
- CNT_W, 32, width of both performance counters (1..32)

Ports:
- i_clk_1  input  1  clock; all state updates on rising edge
- i_rstn_1  input  1  reset; asynchronous assert, active-low
- i_exValid_1  input  1  EX holds a valid instruction this cycle
- i_isCtrl_1  input  1  EX instruction is BRANCH, JAL or JALR
- i_exPC_32  input  32  PC of the EX instruction
- i_isBranch_1  input  1  resolved taken (branch unit output)
- i_branchPC_32  input  32  resolved target (branch unit output)
- i_predTaken_1  input  1  fetch predicted taken
- i_predPC_32  input  32  fetch-predicted target (ignored when i_predTaken_1=0)
- i_redirReady_1  input  1  fetch accepts the redirect
- i_cntClr_1  input  1  synchronous clear of both counters
- o_redirValid_1  output  1  redirect request to fetch
- o_redirPC_32  output  32  correct next PC
- o_flush_1  output  1  kill IF and ID contents
- o_exStall_1  output  1  hold EX; do not retire or resolve
- o_branchCnt_W  output  CNT_W  resolved control-flow count
- o_mispredCnt_W  output  CNT_W  misprediction count

## Operation
- Resolve event R = i_exValid_1 & i_isCtrl_1 & (state==IDLE).
- Correct PC C = i_isBranch_1 ? i_branchPC_32 : i_exPC_32 + 4, computed mod 2^32 (0xFFFF_FFFC + 4 = 0).
- Mispredict M = R & ((i_isBranch_1 != i_predTaken_1) | (i_isBranch_1 & i_predTaken_1 & (i_branchPC_32 != i_predPC_32))).
- FSM has two states:
  - IDLE: on M, register C into o_redirPC_32 and go to REDIR; otherwise stay.
  - REDIR: stay while !i_redirReady_1; on i_redirReady_1, go to IDLE.
- o_redirValid_1, o_flush_1 and o_exStall_1 are all high exactly when state==REDIR. They are state-decoded, glitch-free, and have no combinational path from i_* to any output.
- o_redirPC_32 is stable throughout REDIR. It holds its last value in IDLE.
- EX inputs are ignored in REDIR. The EX instruction is stalled, and any younger op is flushed.
- Counters:
  - o_branchCnt_W increments on R; o_mispredCnt_W increments on M.
  - Both saturate at 2^CNT_W-1.
  - i_cntClr_1 sets both to 0 and takes priority over an increment in the same cycle.
- Misaligned targets are not checked here; that is the responsibility of fetch/exception logic.

## Timing
- Reset (asynchronous, any state, including mid-REDIR): state=IDLE; o_redirValid_1=o_flush_1=o_exStall_1=0; o_redirPC_32=RESET_PC; both counters=0. A pending redirect is dropped.
- Latency: M sampled at edge T makes REDIR outputs visible from T+1 (one cycle).
- Handshake: the transfer completes at the first edge where o_redirValid_1 & i_redirReady_1. The outputs deassert in the following cycle. i_redirReady_1 may be high before valid; this has no effect in IDLE.
- Minimum REDIR duration is 1 cycle (ready already high). There is no maximum, since the block waits indefinitely.
- Back-to-back: a control op in EX in the first IDLE cycle after REDIR is resolved normally.
- Correct predictions cause no bubbles and no output change except the counter increment.

## Structure
- Shared package (core_pkg) holds:
  - the state enum {IDLE, REDIR};
  - a PC_INC constant (32'd4).
- Single module with no sub-module. The saturating counter may be a local generate or function; it is not a separate module.

## Test plan
- Correct prediction: exPC=0x100, taken=1, target=0x200, predTaken=1, predPC=0x200 -> no redirect, branchCnt=1, mispredCnt=0.
- Direction mispredict: exPC=0x100, taken=0, predTaken=1, ready=1 -> redirValid/flush/exStall high for exactly 1 cycle with redirPC=0x104, then IDLE; mispredCnt=1.
- Target mispredict with backpressure: taken=1, target=0x400, predPC=0x300, ready low 3 cycles -> REDIR held 4 cycles, redirPC=0x400 constant; EX inputs toggled during REDIR do not change counts.
- Wrap-around: exPC=0xFFFF_FFFC, taken=0, predTaken=1 -> redirPC=0x0000_0000.
- Counter edges: with CNT_W=4, drive 17 resolves -> branchCnt saturates at 15; clear asserted in the same cycle as a mispredict -> mispredCnt=0 next cycle, but redirect still issued.
- Reset mid-REDIR: deassert i_rstn_1 while redirValid=1 -> all outputs 0 immediately, redirPC=RESET_PC, IDLE after release.
